seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//   Time-multiplexed hex driver for an N-digit common-select 7-segment display.
//   Successor to the single-digit BCD decoder. Scans one digit at a time with a
//   programmable on-time and an anti-ghosting gap. Snapshots the input word once
//   per frame so a display frame never tears.
//   Sits between user logic (counters, DIP values) and the io_seg/io_sel pins.
// PARAMETERS
//   DIGITS        4       number of digits / select lines (>=1)
//   DIGIT_CYCLES  100000  clocks each digit is lit (>=1; 1 ms at 100 MHz)
//   GAP_CYCLES    1000    clocks all digits dark between digits (>=0; 0 = no gap)
// PORTS
//   clk          in   1          system clock (100 MHz)
//   rst_n        in   1          asynchronous active-low reset
//   en           in   1          scan enable; low = display dark
//   value        in   4*DIGITS   hex nibbles; value[3:0] = digit 0 (rightmost)
//   dp           in   DIGITS     decimal point per digit, 1 = lit
//   io_seg       out  8          segments, ACTIVE-LOW; [0]=a..[6]=g, [7]=dp
//   io_sel       out  DIGITS     digit selects, ACTIVE-LOW; io_sel[i] -> digit i
//   frame_start  out  1          1-clock pulse when a new frame snapshot is taken
// BEHAVIOUR
//   - All outputs registered. Reset: io_seg=8'hFF, io_sel=all 1s, frame_start=0,
//     state=GAP, idx=0, cnt=0, shadow value/dp=0. Reset is honoured mid-digit
//     and mid-gap; outputs go dark asynchronously.
//   - FSM states: GAP (all dark), ON (digit idx lit). cnt counts clocks in-state.
//     GAP -> ON after GAP_CYCLES clocks (GAP_CYCLES=0: GAP never occupied,
//       ON->ON directly).
//     ON -> GAP after DIGIT_CYCLES clocks; idx increments on leaving ON and
//       wraps DIGITS-1 -> 0.
//   - Snapshot: on every transition into ON with idx=0, shadow_value<=value and
//     shadow_dp<=dp. The sample is taken from the inputs on that transition edge.
//     frame_start=1 for exactly that cycle. Digits 1..DIGITS-1 display shadow
//     data, never live inputs.
//   - ON outputs: io_sel has only bit idx low. io_seg[6:0]=~hex(shadow nibble idx).
//     io_seg[7]=~shadow_dp[idx].
//   - Hex table (gfedcba, active-high before inversion):
//     0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   - en low: next edge -> state=GAP, idx=0, cnt=0, outputs dark, frame_start=0.
//     On en rising, the sequence restarts with a full GAP, then digit 0 with a
//     fresh snapshot.
//   - Counter width = $clog2(max(DIGIT_CYCLES,GAP_CYCLES)+1). idx width =
//     $clog2(DIGITS) (min 1). DIGITS=1: idx constant 0; a snapshot is taken every
//     ON entry.
//   - Never two select lines active in the same cycle; the select changes only
//     via a dark state or a same-edge swap when GAP_CYCLES=0.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: shadow digits above the highest nonzero
//     nibble are blanked (io_seg[6:0]=7'h7F; select and dp still driven normally).
//     Digit 0 is never blanked, so all-zero shows "0".
//   Undefined: every digit is always decoded, leading zeros included.
// TESTING  (DIGITS=4, DIGIT_CYCLES=4, GAP_CYCLES=1 unless noted)
//   1 Reset: rst_n=0 mid-ON -> io_seg=FF, io_sel=F immediately. After release:
//     1 dark clock, then io_sel=E for 4 clocks, frame_start high on the first.
//   2 Scan order: value=16'h12AF, dp=4'b0100, en=1.
//     -> io_sel E,D,B,7 with io_seg 8E,88,24,F9. Digit 2 dp low (0x24). Then wraps to E.
//   3 Anti-tear: change value 16'h12AF->16'h0000 while idx=2.
//     -> digit 3 still shows 1 (F9). Next frame shows C0 on all digits
//     (C0 only on digit 0 if LEADING_ZERO_BLANK_EN).
//   4 LEADING_ZERO_BLANK_EN: value=16'h0070.
//     -> digits 3,2 io_seg=FF, digit 1=F8, digit 0=C0.
//     Undefined -> digits 3,2=C0.
//   5 en toggle: en=0 mid-digit 2 -> dark next clock. en=1 -> 1 dark clock,
//     then digit 0 with a new snapshot and frame_start.
//   6 GAP_CYCLES=0, DIGITS=1: io_sel stays 0 continuously. frame_start pulses
//     every 4 clocks. Assert at most one io_sel bit low in all tests.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: scans an N-digit active-low 7-segment display one digit at a time.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the highest nonzero one.
module seg7_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int GAP_CYCLES   = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    output logic [7:0]          io_seg,
    output logic [DIGITS-1:0]   io_sel,
    output logic                frame_start,
    output logic                dbg_state
);

    localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic {
        S_GAP = 1'b0,
        S_ON  = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                snap;
    logic [4*DIGITS-1:0] shadow_value, shv_n;
    logic [DIGITS-1:0]   shadow_dp, shdp_n;
    logic [DIGITS-1:0]   blank;
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   sel_n;
    logic [3:0]          nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign dbg_state = (state == S_ON);

    // With no gap the ON state hands over directly to the next digit.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        snap    = 1'b0;
        if (!en) begin
            state_n = S_GAP;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_GAP: begin
                    if (GAP_CYCLES == 0 || cnt == GAP_LAST) begin
                        state_n = S_ON;
                        cnt_n   = '0;
                        snap    = (idx == '0);
                    end
                end
                S_ON: begin
                    if (cnt == DIG_LAST) begin
                        idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        cnt_n = '0;
                        if (GAP_CYCLES == 0) begin
                            snap = (idx_n == '0);
                        end else begin
                            state_n = S_GAP;
                        end
                    end
                end
            endcase
        end
    end

    assign shv_n  = snap ? value : shadow_value;
    assign shdp_n = snap ? dp : shadow_dp;

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (shv_n[4*i +: 4] == 4'h0);
            blank[i]   = zero_above && (i != 0);
        end
    end
`else
    assign blank = '0;
`endif

    // Outputs decode the post-edge state so the snapshot shows on its own edge.
    always_comb begin
        seg_n = 8'hFF;
        sel_n = '1;
        nib   = shv_n[{idx_n, 2'b00} +: 4];
        if (state_n == S_ON) begin
            sel_n[idx_n] = 1'b0;
            seg_n[6:0]   = blank[idx_n] ? 7'h7F : ~hex7(nib);
            seg_n[7]     = ~shdp_n[idx_n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_GAP;
            idx          <= '0;
            cnt          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            io_seg       <= 8'hFF;
            io_sel       <= '1;
            frame_start  <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            shadow_value <= shv_n;
            shadow_dp    <= shdp_n;
            io_seg       <= seg_n;
            io_sel       <= sel_n;
            frame_start  <= snap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: a 4-digit instance (4 on, 1 gap) and a 1-digit no-gap
// instance, each checked every cycle against a timeline model plus literal vectors.
module tb_seg7_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;
    logic        frame_start;
    logic        dbg_state;

    logic        en1;
    logic [3:0]  value1;
    logic [0:0]  dp1;
    logic [7:0]  io_seg1;
    logic [0:0]  io_sel1;
    logic        frame_start1;
    logic        dbg_state1;

    int checks   = 0;
    int failures = 0;

    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] ZB = 8'hFF;
`else
    localparam logic [7:0] ZB = 8'hC0;
`endif

    seg7_scan_mux #(.DIGITS(4), .DIGIT_CYCLES(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp),
        .io_seg(io_seg), .io_sel(io_sel), .frame_start(frame_start), .dbg_state(dbg_state)
    );

    seg7_scan_mux #(.DIGITS(1), .DIGIT_CYCLES(4), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .value(value1), .dp(dp1),
        .io_seg(io_seg1), .io_sel(io_sel1), .frame_start(frame_start1), .dbg_state(dbg_state1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: t = enabled edges since reset or since en was low.
    // The first digit lights after max(gap,1) edges; then slots of gap+on repeat.
    function automatic int m_digit(int t, int nd, int dc, int gc);
        int s;
        s = t - ((gc > 0) ? gc : 1);
        if (t == 0 || s < 0) return -1;
        if (s % (gc + dc) >= dc) return -1;
        return (s / (gc + dc)) % nd;
    endfunction

    function automatic logic m_snap(int t, int nd, int dc, int gc);
        int s;
        s = t - ((gc > 0) ? gc : 1);
        return (m_digit(t, nd, dc, gc) == 0) && (s % (gc + dc) == 0);
    endfunction

    function automatic logic [31:0] m_sel(int d, int nd);
        logic [31:0] r;
        r = (32'd1 << nd) - 32'd1;
        if (d >= 0) r[d] = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] m_seg(int d, int nd, logic [15:0] shv, logic [3:0] shdp);
        logic [7:0] r;
        logic [3:0] n;
        if (d < 0) return 8'hFF;
        n = shv[d*4 +: 4];
        r[7]   = ~shdp[d];
        r[6:0] = ~hex_tbl[n];
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < nd; i++) if (shv[i*4 +: 4] != 4'h0) top = i;
            if (d > top) r[6:0] = 7'h7F;
        end
`endif
        return r;
    endfunction

    int          t0, t1;
    logic [15:0] sh0, sh1;
    logic [3:0]  shdp0, shdp1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0 <= 0; sh0 <= '0; shdp0 <= '0;
        end else if (!en) begin
            t0 <= 0;
        end else begin
            t0 <= t0 + 1;
            if (m_snap(t0 + 1, 4, 4, 1)) begin
                sh0   <= value;
                shdp0 <= dp;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1 <= 0; sh1 <= '0; shdp1 <= '0;
        end else if (!en1) begin
            t1 <= 0;
        end else begin
            t1 <= t1 + 1;
            if (m_snap(t1 + 1, 1, 4, 0)) begin
                sh1   <= {12'h000, value1};
                shdp1 <= {3'b000, dp1};
            end
        end
    end

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk) begin : cmp_p
        int d0, d1;
        d0 = m_digit(t0, 4, 4, 1);
        d1 = m_digit(t1, 1, 4, 0);
        chk("m0_seg", io_seg, m_seg(d0, 4, sh0, shdp0));
        chk("m0_sel", io_sel, m_sel(d0, 4));
        chk("m0_fs", frame_start, m_snap(t0, 4, 4, 1));
        chk("m0_onehot", ($countones(~io_sel) <= 1), 1);
        chk("m1_seg", io_seg1, m_seg(d1, 1, sh1, shdp1));
        chk("m1_sel", io_sel1, m_sel(d1, 1));
        chk("m1_fs", frame_start1, m_snap(t1, 1, 4, 0));
        chk("m1_onehot", ($countones(~io_sel1) <= 1), 1);
    end

    // driver tasks with literal expectations
    task automatic expect_cycle(input logic [3:0] sel, input logic [7:0] seg, input logic fs);
        @(negedge clk);
        chk("lit_sel", io_sel, sel);
        chk("lit_seg", io_seg, seg);
        chk("lit_fs", frame_start, fs);
    endtask

    task automatic expect_digit(input logic [3:0] sel, input logic [7:0] seg, input logic fs);
        expect_cycle(sel, seg, fs);
        repeat (3) expect_cycle(sel, seg, 1'b0);
        expect_cycle(4'hF, 8'hFF, 1'b0);
    endtask

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            value1 = value1 + 4'h3;
            dp1    = ~dp1;
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main_p
        int pulses, sel_bad;
        rst_n = 1'b0; en = 1'b0; value = '0; dp = '0;
        en1 = 1'b1; value1 = 4'h5; dp1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_seg", io_seg, 8'hFF);
        chk("rst_sel", io_sel, 4'hF);
        chk("rst_fs", frame_start, 1'b0);

        // scan order
        en = 1'b1; value = 16'h12AF; dp = 4'b0100;
        rst_n = 1'b1;
        expect_digit(4'hE, 8'h8E, 1'b1);
        expect_digit(4'hD, 8'h88, 1'b0);
        expect_digit(4'hB, 8'h24, 1'b0);
        expect_digit(4'h7, 8'hF9, 1'b0);

        // wrap, then anti-tear: inputs change while digit 2 is lit
        expect_digit(4'hE, 8'h8E, 1'b1);
        expect_digit(4'hD, 8'h88, 1'b0);
        expect_cycle(4'hB, 8'h24, 1'b0);
        value = 16'h0000; dp = 4'b0000;
        repeat (3) expect_cycle(4'hB, 8'h24, 1'b0);
        expect_cycle(4'hF, 8'hFF, 1'b0);
        expect_digit(4'h7, 8'hF9, 1'b0);

        // all-zero frame; 0x0070 arrives after this frame's snapshot
        expect_cycle(4'hE, 8'hC0, 1'b1);
        value = 16'h0070;
        repeat (3) expect_cycle(4'hE, 8'hC0, 1'b0);
        expect_cycle(4'hF, 8'hFF, 1'b0);
        expect_digit(4'hD, ZB, 1'b0);
        expect_digit(4'hB, ZB, 1'b0);
        expect_digit(4'h7, ZB, 1'b0);

        // leading zeros, then en dropped mid digit 2
        expect_digit(4'hE, 8'hC0, 1'b1);
        expect_digit(4'hD, 8'hF8, 1'b0);
        expect_cycle(4'hB, ZB, 1'b0);
        en = 1'b0;
        expect_cycle(4'hF, 8'hFF, 1'b0);
        expect_cycle(4'hF, 8'hFF, 1'b0);
        value = 16'h5A3C; dp = 4'b1001;
        expect_cycle(4'hF, 8'hFF, 1'b0);
        en = 1'b1;
        expect_digit(4'hE, 8'h46, 1'b1);
        expect_digit(4'hD, 8'hB0, 1'b0);
        expect_digit(4'hB, 8'h88, 1'b0);
        expect_digit(4'h7, 8'h12, 1'b0);

        // asynchronous reset in the middle of digit 0
        expect_cycle(4'hE, 8'h46, 1'b1);
        expect_cycle(4'hE, 8'h46, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_seg", io_seg, 8'hFF);
        chk("async_sel", io_sel, 4'hF);
        chk("async_fs", frame_start, 1'b0);
        chk("async_sel1", io_sel1, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single digit, no gap: select held low, snapshot every 4 clocks
        pulses = 0; sel_bad = 0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (frame_start1) pulses++;
            if (io_sel1 != 1'b0) sel_bad++;
            if (i < 19) @(negedge clk);
        end
        chk("d1_pulses", pulses, 5);
        chk("d1_sel_low", sel_bad, 0);
        expect_cycle(4'hE, 8'h46, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
